// File: rtl/ks_wide_add_scheduler.sv
// Arbitrates two requesters onto one shared 16-bit prefix adder and walks a
// multi-word addition through it one slice per cycle, carrying via a register.
module ks_wide_add_scheduler #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [16*WORDS-1:0]   req0_a,
    input  logic [16*WORDS-1:0]   req0_b,
    input  logic                  req0_cin,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [16*WORDS-1:0]   req1_a,
    input  logic [16*WORDS-1:0]   req1_b,
    input  logic                  req1_cin,

    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [16*WORDS-1:0]   res_sum,
    output logic                  res_cout,
    output logic                  res_id,

    output logic [15:0]           ks_a,
    output logic [15:0]           ks_b,
    output logic                  ks_cin,
    input  logic [16:0]           ks_sum
);

    localparam int W     = 16 * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q;
    logic             prio_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             res_valid_q;
    logic [W-1:0]     res_sum_q;
    logic             res_cout_q;
    logic             res_id_q;

    logic             grant0;
    logic             grant1;
    logic             accept;
    logic [W-1:0]     a_d;
    logic [W-1:0]     b_d;
    logic             cin_d;

    // NOTE: ready is a combinational function of valid and the priority bit, so
    // a requester sees its grant in the same cycle it raises valid.
    assign grant0     = req0_valid & (~req1_valid | ~prio_q);
    assign grant1     = req1_valid & ~grant0;
    assign req0_ready = (state_q == IDLE) & grant0;
    assign req1_ready = (state_q == IDLE) & grant1;
    assign accept     = req0_ready | req1_ready;

    assign a_d   = grant1 ? req1_a   : req0_a;
    assign b_d   = grant1 ? req1_b   : req0_b;
    assign cin_d = grant1 ? req1_cin : req0_cin;

    // The adder sees zeros whenever no slice is being processed.
    always_comb begin
        ks_a   = '0;
        ks_b   = '0;
        ks_cin = 1'b0;
        if (state_q == RUN) begin
            ks_a   = a_q[16*idx_q +: 16];
            ks_b   = b_q[16*idx_q +: 16];
            ks_cin = carry_q;
        end
    end

    // NOTE: operand registers carry no reset; they are always reloaded on
    // acceptance before being read, so resetting them buys nothing.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_id_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        res_id_q <= grant1;
                        idx_q    <= '0;
                        carry_q  <= cin_d;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    res_sum_q[16*idx_q +: 16] <= ks_sum[15:0];
                    carry_q                   <= ks_sum[16];
                    if (idx_q == LAST_IDX) begin
                        idx_q       <= '0;
                        res_cout_q  <= ks_sum[16];
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        prio_q      <= ~res_id_q;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_ks_wide_add_scheduler.sv
// Scoreboard bench: a WORDS=4 scheduler driven with directed vectors, plus a
// WORDS=1 instance for the single-slice corner.
module tb_ks_wide_add_scheduler;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] sum;
        logic        cout;
    } vec_t;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        id;
        int          hs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic           req0_valid = 1'b0, req1_valid = 1'b0;
    logic           req0_ready, req1_ready;
    logic [W-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic           req0_cin = 1'b0, req1_cin = 1'b0;
    logic           res_valid, res_cout, res_id;
    logic           res_ready = 1'b1;
    logic [W-1:0]   res_sum;
    logic [15:0]    ks_a, ks_b;
    logic           ks_cin;
    logic [16:0]    ks_sum;

    assign ks_sum = {1'b0, ks_a} + {1'b0, ks_b} + {16'd0, ks_cin};

    ks_wide_add_scheduler #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_cout(res_cout), .res_id(res_id),
        .ks_a(ks_a), .ks_b(ks_b), .ks_cin(ks_cin), .ks_sum(ks_sum)
    );

    logic        s_valid = 1'b0, s_ready, s_idle_valid = 1'b0, s_idle_ready;
    logic [15:0] s_a = '0, s_b = '0, s_zero = '0;
    logic        s_cin = 1'b0;
    logic        s_res_valid, s_res_cout, s_res_id, s_res_ready = 1'b1;
    logic [15:0] s_res_sum, s_ks_a, s_ks_b;
    logic        s_ks_cin;
    logic [16:0] s_ks_sum;

    assign s_ks_sum = {1'b0, s_ks_a} + {1'b0, s_ks_b} + {16'd0, s_ks_cin};

    ks_wide_add_scheduler #(.WORDS(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(s_valid), .req0_ready(s_ready),
        .req0_a(s_a), .req0_b(s_b), .req0_cin(s_cin),
        .req1_valid(s_idle_valid), .req1_ready(s_idle_ready),
        .req1_a(s_zero), .req1_b(s_zero), .req1_cin(1'b0),
        .res_valid(s_res_valid), .res_ready(s_res_ready), .res_sum(s_res_sum),
        .res_cout(s_res_cout), .res_id(s_res_id),
        .ks_a(s_ks_a), .ks_b(s_ks_b), .ks_cin(s_ks_cin), .ks_sum(s_ks_sum)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_exp(input vec_t v, input logic id);
        exp_t e;
        e.sum  = v.sum;
        e.cout = v.cout;
        e.id   = id;
        e.hs   = cyc;
        sb.push_back(e);
    endtask

    // Monitor: latency on each rising res_valid, payload on each handshake,
    // and quiet adder/ready lines while a result is pending.
    always @(negedge clk) begin
        if (res_valid && !prev_valid) begin
            if (sb.size() == 0) check("unexpected_result", 64'd1, 64'd0);
            else check("latency", 64'(cyc), 64'(sb[0].hs + WORDS + 1));
        end
        if (res_valid) begin
            check("done_no_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
            check("done_ks_idle", {31'd0, ks_a, ks_b, ks_cin}, 64'd0);
        end
        if (res_valid && res_ready && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("res_sum",  res_sum,  e.sum);
            check("res_cout", {63'd0, res_cout}, {63'd0, e.cout});
            check("res_id",   {63'd0, res_id},   {63'd0, e.id});
        end
        prev_valid <= res_valid;
    end

    // Raises the selected valids, collects handshakes, checks grant order and
    // that at most one ready is high.
    task automatic serve(input logic v0, input vec_t x0, input logic v1, input vec_t x1,
                         input logic first_id);
        logic p0, p1, first;
        int   guard;
        @(posedge clk); #1;
        if (v0) begin req0_valid = 1'b1; req0_a = x0.a; req0_b = x0.b; req0_cin = x0.cin; end
        if (v1) begin req1_valid = 1'b1; req1_a = x1.a; req1_b = x1.b; req1_cin = x1.cin; end
        p0 = v0; p1 = v1; first = 1'b1; guard = 0;
        while ((p0 || p1) && guard < 100) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                check("ready_onehot", {63'd0, req0_ready & req1_ready}, 64'd0);
                if (first) check("grant_order", {63'd0, req1_ready}, {63'd0, first_id});
                first = 1'b0;
                if (req0_ready) begin push_exp(x0, 1'b0); p0 = 1'b0; end
                else begin push_exp(x1, 1'b1); p1 = 1'b0; end
            end
            @(posedge clk); #1;
            if (!p0) req0_valid = 1'b0;
            if (!p1) req1_valid = 1'b0;
            guard++;
        end
        if (p0 || p1) begin
            check("accept_timeout", 64'd1, 64'd0);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || res_valid) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0 || res_valid) check("drain_timeout", 64'd1, 64'd0);
    endtask

    vec_t v_carry, v_wrap, v_cin, c0, c1, c2, c3, v_bp, v_bp1, v_abort, v_fresh, none;
    int   t_hs, guard;

    initial begin
        v_carry = '{64'h0000FFFFFFFFFFFF, 64'h1, 1'b0, 64'h0001000000000000, 1'b0};
        v_wrap  = '{64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0, 64'h0, 1'b1};
        v_cin   = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0};
        c0      = '{64'h1234567890ABCDEF, 64'h1111111111111111, 1'b0, 64'h23456789A1BCDF00, 1'b0};
        c1      = '{64'h8000000000000000, 64'h8000000000000000, 1'b1, 64'h1, 1'b1};
        c2      = '{64'h00000000FFFF0000, 64'h0000000000010000, 1'b0, 64'h0000000100000000, 1'b0};
        c3      = '{64'h7FFFFFFFFFFFFFFF, 64'h0, 1'b1, 64'h8000000000000000, 1'b0};
        v_bp    = '{64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        v_bp1   = '{64'h00000000FFFFFFFF, 64'h00000000FFFFFFFF, 1'b1, 64'h00000001FFFFFFFF, 1'b0};
        v_abort = '{64'hDEADBEEFDEADBEEF, 64'h1, 1'b0, 64'hDEADBEEFDEADBEF0, 1'b0};
        v_fresh = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        none    = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst_res_sum", res_sum, 64'd0);
        check("rst_res_cout_id", {62'd0, res_cout, res_id}, 64'd0);
        check("rst_ks", {31'd0, ks_a, ks_b, ks_cin}, 64'd0);
        check("rst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);

        serve(1'b1, c0, 1'b1, c1, 1'b0);
        serve(1'b1, c2, 1'b1, c3, 1'b0);
        serve(1'b1, v_carry, 1'b0, none, 1'b0);
        serve(1'b0, none, 1'b1, v_wrap, 1'b1);
        serve(1'b0, none, 1'b1, v_cin, 1'b1);

        wait_drain();
        res_ready = 1'b0;
        serve(1'b1, v_bp, 1'b0, none, 1'b0);
        guard = 0;
        while (!res_valid && guard < 20) begin @(negedge clk); guard++; end
        check("bp_valid", {63'd0, res_valid}, 64'd1);
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_a = v_bp1.a; req1_b = v_bp1.b; req1_cin = v_bp1.cin;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {63'd0, res_valid}, 64'd1);
            check("bp_hold_sum", res_sum, v_bp.sum);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        @(negedge clk);
        check("bp_handshake", {63'd0, res_valid}, 64'd1);
        @(negedge clk);
        check("idle_next_cycle", {63'd0, req1_ready}, 64'd1);
        if (req1_ready) begin
            push_exp(v_bp1, 1'b1);
            @(posedge clk); #1 req1_valid = 1'b0;
        end else begin
            serve(1'b0, none, 1'b1, v_bp1, 1'b1);
        end

        wait_drain();
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = v_abort.a; req0_b = v_abort.b; req0_cin = v_abort.cin;
        @(negedge clk);
        check("abort_accept", {63'd0, req0_ready}, 64'd1);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("abort_res_valid", {63'd0, res_valid}, 64'd0);
        check("abort_res_sum", res_sum, 64'd0);
        check("abort_res_cout_id", {62'd0, res_cout, res_id}, 64'd0);
        check("abort_ks", {31'd0, ks_a, ks_b, ks_cin}, 64'd0);
        check("abort_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
        repeat (10) @(negedge clk);
        serve(1'b1, v_fresh, 1'b0, none, 1'b0);
        wait_drain();

        @(posedge clk); #1;
        s_valid = 1'b1; s_a = 16'hFFFF; s_b = 16'h0001; s_cin = 1'b1;
        @(negedge clk);
        check("w1_ready", {63'd0, s_ready}, 64'd1);
        @(posedge clk); #1 s_valid = 1'b0;
        @(negedge clk);
        check("w1_valid_early", {63'd0, s_res_valid}, 64'd0);
        @(negedge clk);
        check("w1_valid", {63'd0, s_res_valid}, 64'd1);
        check("w1_sum", {48'd0, s_res_sum}, 64'h0001);
        check("w1_cout_id", {62'd0, s_res_cout, s_res_id}, 64'h2);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
